vend_coin_sched: RTL and testbench
==================================

# vend_coin_sched

Two-slot coin scheduler placed in front of the vending core (`eem16_proj3`).
- Accepts coins from two independent coin acceptors (slot A, slot B) over valid/ready handshakes.
- Arbitrates between the slots round-robin and serialises coins onto the core's single 2-bit coin input `x`, one coin per core cycle with enforced idle gaps.
- Stalls while the core reports a vend on `z`, and sequences a core reset on customer cancel.

## Interface
- `GAP`, 1: idle cycles of `x=2'b00` forced after every issued coin (0 allowed).
- `VEND_HOLD`, 2: idle cycles held after the last cycle in which `vend_z != 0`.
- `CNT_W`, 8: width of per-slot issued-coin counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `a_valid`  in  1  slot A has a coin.
- `a_coin`  in  2  slot A coin code: 01 nickel, 11 dime, 00/10 invalid.
- `a_ready`  out  1  slot A holding register empty.
- `b_valid`, `b_coin`, `b_ready`: same as the slot A ports, for slot B.
- `cancel`  in  1  customer cancel request, level-sampled.
- `vend_z`  in  2  core output `z`; nonzero means a vend/change event is in progress.
- `x`  out  2  coin code to the core `x`, registered.
- `core_reset`  out  1  one-cycle pulse to the core reset, registered.
- `reject`  out  1  one-cycle pulse: an invalid coin code was accepted and dropped.
- `a_count`, `b_count`  out  `CNT_W`  coins issued per slot, saturating.

## Operation
- Each slot has a one-entry holding register (code + full flag).
- `*_ready = ~full & (state != CANCEL)`, combinational from registered state only. There is no same-cycle refill on issue.
- A transfer occurs when `valid & ready` at a rising edge.
  - Codes 01 and 11 load the register.
  - Codes 00 and 10 are dropped: the register stays empty and `reject` pulses the next cycle. Simultaneous rejects on both slots produce a single pulse.
- FSM states: IDLE, ISSUE, GAP, HOLD, CANCEL. Reset state is IDLE.
- Per-cycle priority in every state except CANCEL: `cancel`, then `vend_z != 0`, then issue.
- IDLE:
  - `cancel` → CANCEL.
  - else `vend_z != 0` → HOLD.
  - else if either register is full → ISSUE. The granted coin is registered onto `x`, that register is cleared, and that slot's count increments.
- ISSUE lasts exactly 1 cycle, with `x` = granted code.
  - `cancel` → CANCEL.
  - `vend_z != 0` → HOLD.
  - else → GAP if `GAP > 0`, otherwise → IDLE.
  - A back-to-back issue with `GAP = 0` still passes through IDLE, so the minimum issue spacing is 2 cycles.
- GAP: `x = 00` for `GAP` cycles, then → IDLE.
- HOLD: `x = 00`.
  - The counter reloads to `VEND_HOLD` on every cycle with `vend_z != 0`.
  - Exit → IDLE when the counter reaches 0 while `vend_z == 0`.
- CANCEL: 1 cycle.
  - `core_reset = 1`, both holding registers flushed, both readies low, `x = 00`.
  - → IDLE. Counts are not cleared.
- Round-robin: the last-grant pointer resets to B, so A wins the first tie.
  - When both registers are full, the slot not granted last wins.
  - When only one is full, it is granted.
  - The pointer updates on every grant.
- Counters: increment on grant and saturate at `2^CNT_W - 1`. Cleared only by `reset`.
- `x` is 00 in every state except ISSUE.

## Timing
- Reset values: `x = 00`, `core_reset = 0`, `reject = 0`, `a_count = b_count = 0`, `a_ready = b_ready = 1`, state IDLE, pointer = B.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronously).
  - In-flight coins are lost.
- Latency, assuming IDLE with no stall:
  - Coin accepted at edge N → register full after N → grant at edge N+1 → `x` valid for the cycle after N+1.
  - `x` is 00 again after edge N+2.
- Hand-off between slots: a slot whose coin is issued at edge M shows `ready = 1` after M, and can be refilled at edge M+1.
- `vend_z` asserted during ISSUE: the coin already on `x` completes its single cycle, then the FSM goes to HOLD.
- `cancel` held for multiple cycles:
  - Each IDLE cycle re-enters CANCEL, so `core_reset` pulses on alternate cycles.
  - No coins are issued while `cancel` is held.

## Test plan
- Slot A sends 5 nickels (`a_coin = 01`) back-to-back, `GAP = 1`. `x` must read 01 for one cycle every 3 cycles, exactly 5 times, then `a_count = 5` and `b_count = 0`.
- Both slots preloaded, A = 11 and B = 01, then both refilled. Issue order on `x` must be 11, 01, A, B alternating.
- Coin queued and `vend_z = 10` pulsed for 1 cycle. `x` stays 00 for at least `VEND_HOLD = 2` cycles after `vend_z` drops, then the queued coin is issued.
- Slot A nickel accepted, `cancel` asserted the next cycle before issue:
  - `core_reset` pulses once and the coin is flushed.
  - `x` never reads 01.
  - `a_count` is unchanged and `a_ready` is low during the CANCEL cycle.
- `a_coin = 10` and `b_coin = 00` accepted in the same cycle. `reject` pulses once, `x` stays 00, and the counts are unchanged.
- `CNT_W = 2`, 5 coins issued on slot B: `b_count` saturates at 3. Asynchronous `reset` mid-ISSUE forces `x = 00` and the counts to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/vend_coin_sched.sv
`default_nettype none
// ============================================================================
// Module   : vend_coin_sched
// Brief    : Two-slot round-robin coin scheduler serialising coins onto the
//            vending core's x input, with vend stall and cancel sequencing.
// Revision : 1.0
// ============================================================================
module vend_coin_sched #(
    parameter int GAP       = 1,
    parameter int VEND_HOLD = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [1:0]       a_coin,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [1:0]       b_coin,
    output logic             b_ready,
    input  logic             cancel,
    input  logic [1:0]       vend_z,
    output logic [1:0]       x,
    output logic             core_reset,
    output logic             reject,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    localparam int C_GAP_W  = (GAP < 2) ? 1 : $clog2(GAP + 1);
    localparam int C_HOLD_W = (VEND_HOLD < 2) ? 1 : $clog2(VEND_HOLD + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_GAP    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_CANCEL = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 a_full_q, a_full_d, b_full_q, b_full_d;
    logic [1:0]           a_code_q, a_code_d, b_code_q, b_code_d;
    logic                 last_b_q, last_b_d;
    logic [1:0]           x_q, x_d;
    logic                 core_reset_q, core_reset_d;
    logic                 reject_q, reject_d;
    logic [CNT_W-1:0]     a_count_q, a_count_d, b_count_q, b_count_d;
    logic [C_GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [C_HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic w_a_xfer, w_b_xfer, w_vend, w_grant_b;

    assign a_ready    = ~a_full_q & (state_q != ST_CANCEL);
    assign b_ready    = ~b_full_q & (state_q != ST_CANCEL);
    assign w_a_xfer   = a_valid & a_ready;
    assign w_b_xfer   = b_valid & b_ready;
    assign w_vend     = (vend_z != 2'b00);
    // B wins only if A is empty or A was granted last.
    assign w_grant_b  = b_full_q & (~a_full_q | ~last_b_q);

    assign x          = x_q;
    assign core_reset = core_reset_q;
    assign reject     = reject_q;
    assign a_count    = a_count_q;
    assign b_count    = b_count_q;

    always_comb begin
        state_d      = state_q;
        a_full_d     = a_full_q;
        a_code_d     = a_code_q;
        b_full_d     = b_full_q;
        b_code_d     = b_code_q;
        last_b_d     = last_b_q;
        x_d          = 2'b00;
        core_reset_d = 1'b0;
        a_count_d    = a_count_q;
        b_count_d    = b_count_q;
        gap_cnt_d    = gap_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        reject_d     = (w_a_xfer & ~a_coin[0]) | (w_b_xfer & ~b_coin[0]);

        if (w_a_xfer && a_coin[0]) begin
            a_full_d = 1'b1;
            a_code_d = a_coin;
        end
        if (w_b_xfer && b_coin[0]) begin
            b_full_d = 1'b1;
            b_code_d = b_coin;
        end

        if (state_q == ST_CANCEL) begin
            a_full_d = 1'b0;
            b_full_d = 1'b0;
            state_d  = ST_IDLE;
        end else if (cancel) begin
            state_d      = ST_CANCEL;
            core_reset_d = 1'b1;
        end else if (w_vend) begin
            state_d    = ST_HOLD;
            hold_cnt_d = C_HOLD_W'(VEND_HOLD);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (a_full_q || b_full_q) begin
                        state_d  = ST_ISSUE;
                        last_b_d = w_grant_b;
                        if (w_grant_b) begin
                            x_d      = b_code_q;
                            b_full_d = 1'b0;
                            if (b_count_q != C_CNT_MAX) b_count_d = b_count_q + CNT_W'(1);
                        end else begin
                            x_d      = a_code_q;
                            a_full_d = 1'b0;
                            if (a_count_q != C_CNT_MAX) a_count_d = a_count_q + CNT_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = C_GAP_W'(GAP);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q <= C_GAP_W'(1)) state_d = ST_IDLE;
                    else gap_cnt_d = gap_cnt_q - C_GAP_W'(1);
                end
                ST_HOLD: begin
                    // Counter was reloaded on the last vend cycle; leave once it runs out.
                    if (hold_cnt_q <= C_HOLD_W'(1)) state_d = ST_IDLE;
                    else hold_cnt_d = hold_cnt_q - C_HOLD_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            a_full_q     <= 1'b0;
            a_code_q     <= 2'b00;
            b_full_q     <= 1'b0;
            b_code_q     <= 2'b00;
            last_b_q     <= 1'b1;
            x_q          <= 2'b00;
            core_reset_q <= 1'b0;
            reject_q     <= 1'b0;
            a_count_q    <= '0;
            b_count_q    <= '0;
            gap_cnt_q    <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            a_full_q     <= a_full_d;
            a_code_q     <= a_code_d;
            b_full_q     <= b_full_d;
            b_code_q     <= b_code_d;
            last_b_q     <= last_b_d;
            x_q          <= x_d;
            core_reset_q <= core_reset_d;
            reject_q     <= reject_d;
            a_count_q    <= a_count_d;
            b_count_q    <= b_count_d;
            gap_cnt_q    <= gap_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vend_coin_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_coin_sched
// Brief    : Scoreboard bench for vend_coin_sched (per-slot coin queues plus
//            timing rules), with directed cancel/reject/saturation cases.
// Revision : 1.0
// ============================================================================
module tb_vend_coin_sched;
    localparam int GAP       = 1;
    localparam int VEND_HOLD = 2;

    typedef struct {
        logic [1:0] code;
        int         edge_n;
    } coin_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0, cancel = 1'b0;
    logic [1:0] a_coin = 2'b00, b_coin = 2'b00, vend_z = 2'b00;
    logic       a_ready, b_ready, core_reset, reject;
    logic [1:0] x;
    logic [7:0] a_count, b_count;
    logic       a_ready_s, b_ready_s, core_reset_s, reject_s;
    logic [1:0] x_s, a_count_s, b_count_s;

    int    checks = 0, errors = 0, cyc = 0;
    bit    mon_en = 1'b0;
    coin_t qa[$], qb[$];
    int    rej_q[$];
    bit    vend_hist[int];
    int    iss_cyc[$];
    logic [1:0] iss_code[$];
    int    ma = 0, mb = 0, last_issue = -1000;
    bit    last_b = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vend_coin_sched #(.GAP(GAP), .VEND_HOLD(VEND_HOLD), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_coin(a_coin), .a_ready(a_ready),
        .b_valid(b_valid), .b_coin(b_coin), .b_ready(b_ready),
        .cancel(cancel), .vend_z(vend_z), .x(x), .core_reset(core_reset),
        .reject(reject), .a_count(a_count), .b_count(b_count)
    );

    vend_coin_sched #(.GAP(GAP), .VEND_HOLD(VEND_HOLD), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_coin(a_coin), .a_ready(a_ready_s),
        .b_valid(b_valid), .b_coin(b_coin), .b_ready(b_ready_s),
        .cancel(cancel), .vend_z(vend_z), .x(x_s), .core_reset(core_reset_s),
        .reject(reject_s), .a_count(a_count_s), .b_count(b_count_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One call governs exactly the next rising edge.
    task automatic drive_cycle(input bit av, input logic [1:0] ac, input bit bv,
                               input logic [1:0] bc, input logic [1:0] vz, input bit cn,
                               output bit acc_a, output bit acc_b);
        coin_t c;
        @(posedge clk);
        #2;
        a_valid = av; a_coin = ac; b_valid = bv; b_coin = bc; vend_z = vz; cancel = cn;
        acc_a = av && a_ready;
        acc_b = bv && b_ready;
        if (mon_en) begin
            c.edge_n = cyc + 1;
            if (acc_a && ac[0]) begin c.code = ac; qa.push_back(c); end
            if (acc_b && bc[0]) begin c.code = bc; qb.push_back(c); end
            if ((acc_a && !ac[0]) || (acc_b && !bc[0])) rej_q.push_back(cyc + 1);
            if (vz != 2'b00) vend_hist[cyc + 1] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bit d1, d2;
        repeat (n) drive_cycle(1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, d1, d2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; cancel = 1'b0; vend_z = 2'b00;
        repeat (2) @(negedge clk);
        qa.delete(); qb.delete(); rej_q.delete(); vend_hist.delete();
        iss_cyc.delete(); iss_code.delete();
        ma = 0; mb = 0; last_b = 1'b1; last_issue = -1000;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        coin_t c;
        bit a_has, b_has, gb, exp_rej, vend_recent;
        if (mon_en && !reset) begin
            exp_rej = 1'b0;
            if (rej_q.size() > 0 && rej_q[0] == cyc) begin
                exp_rej = 1'b1;
                void'(rej_q.pop_front());
            end
            chk("reject", reject, exp_rej);
            if (x != 2'b00) begin
                vend_recent = 1'b0;
                for (int d = 0; d <= VEND_HOLD; d++)
                    if (vend_hist.exists(cyc - d)) vend_recent = 1'b1;
                chk("x_in_vend_hold", vend_recent, 0);
                chk("x_issue_spacing", (cyc - last_issue) > (GAP + 1), 1);
                a_has = qa.size() > 0 && qa[0].edge_n < cyc;
                b_has = qb.size() > 0 && qb[0].edge_n < cyc;
                if (!a_has && !b_has) begin
                    chk("x_without_pending_coin", x, 0);
                end else begin
                    gb = b_has && (!a_has || !last_b);
                    if (gb) begin c = qb.pop_front(); mb++; end
                    else    begin c = qa.pop_front(); ma++; end
                    last_b = gb;
                    chk("x_code", x, c.code);
                end
                last_issue = cyc;
                iss_cyc.push_back(cyc);
                iss_code.push_back(x);
            end
            chk("a_count", a_count, ma);
            chk("b_count", b_count, mb);
            chk("a_count_sat", a_count_s, (ma > 3) ? 3 : ma);
            chk("b_count_sat", b_count_s, (mb > 3) ? 3 : mb);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual time %0t required finish before 500000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit aa, ab, found;
        int na, nb, ve, pulses, xbad, rej;
        logic [1:0] vz;

        @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_core_reset", core_reset, 0);
        chk("rst_reject", reject, 0);
        chk("rst_counts", {a_count, b_count}, 0);
        chk("rst_ready", {a_ready, b_ready, a_ready_s}, 3'b111);
        chk("rst_sat_outputs", {core_reset_s, reject_s, x_s}, 0);
        do_reset();
        mon_en = 1'b1;

        // Five back-to-back nickels on slot A.
        na = 0;
        for (int i = 0; i < 60 && na < 5; i++) begin
            drive_cycle(1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, aa, ab);
            if (aa) na++;
        end
        idle(12);
        chk("p1_issue_count", iss_code.size(), 5);
        for (int i = 0; i < iss_code.size(); i++) begin
            chk("p1_code", iss_code[i], 1);
            if (i > 0) chk("p1_period", iss_cyc[i] - iss_cyc[i-1], 3);
        end
        chk("p1_a_count", a_count, 5);
        chk("p1_b_count", b_count, 0);

        // Both slots loaded together and kept refilled: strict A/B alternation.
        do_reset();
        na = 0; nb = 0;
        for (int i = 0; i < 80 && (na < 3 || nb < 3); i++) begin
            drive_cycle(na < 3, 2'b11, nb < 3, 2'b01, 2'b00, 1'b0, aa, ab);
            if (aa) na++;
            if (ab) nb++;
        end
        idle(12);
        chk("p2_issue_count", iss_code.size(), 6);
        for (int i = 0; i < iss_code.size(); i++)
            chk("p2_order", iss_code[i], (i % 2 == 0) ? 3 : 1);

        // Queued coin held back by a one-cycle vend pulse.
        do_reset();
        drive_cycle(1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, aa, ab);
        drive_cycle(1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0, aa, ab);
        ve = cyc + 1;
        idle(12);
        chk("p3_issue_count", iss_code.size(), 1);
        if (iss_cyc.size() > 0) begin
            chk("p3_code", iss_code[0], 1);
            chk("p3_release", iss_cyc[0] - ve, VEND_HOLD + 1);
        end

        // Randomised traffic with vend stalls and invalid codes.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            vz = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), vz, 1'b0, aa, ab);
        end
        for (int i = 0; i < 40 && (qa.size() + qb.size()) > 0; i++) idle(1);
        idle(4);
        chk("p4_drain", qa.size() + qb.size(), 0);
        chk("p4_enough_issues", iss_code.size() > 20, 1);
        mon_en = 1'b0;

        // Cancel the cycle after a nickel is accepted.
        do_reset();
        drive_cycle(1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, aa, ab);
        chk("c_accept", aa, 1);
        drive_cycle(1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, aa, ab);
        pulses = 0; xbad = 0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, aa, ab);
            @(negedge clk);
            if (core_reset) begin
                pulses++;
                chk("c_ready_in_cancel", {a_ready, b_ready}, 0);
            end
            if (x != 2'b00) xbad++;
        end
        chk("c_pulses", pulses, 1);
        chk("c_no_issue", xbad, 0);
        chk("c_a_count", a_count, 0);
        chk("c_ready_after", a_ready, 1);

        // Cancel held for six cycles with slot A offering coins.
        do_reset();
        pulses = 0; xbad = 0;
        for (int i = 0; i < 14; i++) begin
            drive_cycle(i < 6, 2'b01, 1'b0, 2'b00, 2'b00, i < 6, aa, ab);
            @(negedge clk);
            if (core_reset) pulses++;
            if (x != 2'b00) xbad++;
        end
        chk("ch_pulses", pulses, 3);
        chk("ch_no_issue", xbad, 0);
        chk("ch_a_count", a_count, 0);

        // Two invalid codes accepted in the same cycle.
        do_reset();
        drive_cycle(1'b1, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, aa, ab);
        chk("r_accept_both", aa && ab, 1);
        rej = 0; xbad = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, aa, ab);
            @(negedge clk);
            if (reject) rej++;
            if (x != 2'b00) xbad++;
        end
        chk("r_pulses", rej, 1);
        chk("r_no_issue", xbad, 0);
        chk("r_counts", {a_count, b_count}, 0);
        chk("r_ready", {a_ready, b_ready}, 2'b11);

        // Saturation of the narrow counter, then asynchronous reset mid-issue.
        do_reset();
        nb = 0;
        for (int i = 0; i < 80 && nb < 5; i++) begin
            drive_cycle(1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, aa, ab);
            if (ab) nb++;
        end
        idle(10);
        chk("s_b_count_sat", b_count_s, 3);
        chk("s_b_count", b_count, 5);
        drive_cycle(1'b0, 2'b00, 1'b1, 2'b11, 2'b00, 1'b0, aa, ab);
        drive_cycle(1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, aa, ab);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (x != 2'b00) found = 1'b1;
        end
        chk("s_issue_seen", found, 1);
        chk("s_issue_code", x, 3);
        chk("s_b_count6", b_count, 6);
        reset = 1'b1;
        #1;
        chk("s_async_x", {x, x_s}, 0);
        chk("s_async_counts", {a_count, b_count, a_count_s, b_count_s}, 0);
        chk("s_async_ready", {a_ready, b_ready, b_ready_s}, 3'b111);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
